rd_alu_issue: RTL
=================

// Module: rd_alu_issue
// PURPOSE
//   Request/response front end for the combinational 64-bit ALU (rd_ALU_top); this is the side that drives it.
//   Accepts operations through a valid/ready request port, registers operands, drives rd_ALU_top,
//   and captures result, zero flag and tag into an output FIFO drained through a valid/ready response port.
//   Sits between decode/issue and writeback/branch resolution, decoupling upstream from downstream stalls.
// PARAMETERS
//   DEPTH   4   response FIFO entries; power of two, >= 2
//   TAG_W   5   width of the opaque tag (e.g. destination register index) carried with each op
// PORTS
//   clk_i         in   1                   clock, all state updates on rising edge
//   rst_i         in   1                   synchronous reset, active-high
//   req_valid_i   in   1                   request valid
//   req_ready_o   out  1                   request ready
//   req_a_i       in   64                  operand A
//   req_b_i       in   64                  operand B
//   req_instr_i   in   4                   instruction bits forwarded to rd_ALU_top instruction_i
//   req_aluop_i   in   2                   ALUop forwarded to rd_ALU_top ALUop_i
//   req_tag_i     in   TAG_W               tag returned unchanged with the result
//   rsp_valid_o   out  1                   FIFO head valid
//   rsp_ready_i   in   1                   downstream accepts head
//   rsp_c_o       out  64                  result at FIFO head
//   rsp_zero_o    out  1                   zero flag at FIFO head
//   rsp_tag_o     out  TAG_W               tag at FIFO head
//   count_o       out  $clog2(DEPTH+1)     FIFO occupancy, registered
// BEHAVIOUR
//   Clock/reset: one clock (clk_i); reset synchronous, active-high (rst_i).
//   Reset: s1_valid=0, FIFO empty, pointers=0, count_o=0, rsp_valid_o=0, rsp_c_o=0, rsp_zero_o=0, rsp_tag_o=0.
//     Reset mid-operation flushes stage register and FIFO; in-flight ops are discarded, never emitted.
//   Stage 1 (operand register): req accepted when req_valid_i && req_ready_o at rising edge; A, B, instr,
//     aluop, tag loaded, s1_valid=1. rd_ALU_top is driven combinationally from stage-1 registers.
//   pop  = rsp_valid_o && rsp_ready_i.
//   push = s1_valid && (count < DEPTH || pop). Writes {C_o, zero_o, tag} into FIFO at wr_ptr.
//   s1_valid next = req accepted ? 1 : (push ? 0 : s1_valid)  (accept and push may coincide).
//   req_ready_o = !s1_valid || push  (combinational; full FIFO with no pop => ready=0, stage 1 holds).
//   Operands held in stage 1 stay stable while stalled; result recomputed each cycle from same inputs.
//   FIFO: show-ahead; rsp_* reflect the head entry whenever rsp_valid_o=1; rsp_valid_o = (count != 0).
//     When empty, rsp_c_o/rsp_zero_o/rsp_tag_o hold their last values (0 after reset); bench must not check them.
//   Pointers log2(DEPTH) bits, wrap naturally from DEPTH-1 to 0.
//   count next = count + push - pop; push and pop in the same cycle leave count unchanged,
//     legal at full and at one entry (push at full only when pop).
//   Latency: request accepted at edge E0 -> entry written at E1 -> rsp_valid_o=1 after E1 (2 edges) if FIFO not full.
//   Throughput: one op per cycle sustained while rsp_ready_i=1.
//   Ordering: strict in-order; responses leave in acceptance order; no op dropped or duplicated.
//   Flags carry, overflow and negative are not exported.
// TESTING
//   ALUop=00, A=5, B=7, tag=3, rsp_ready_i=1 -> 2 edges later rsp_c_o=12, rsp_zero_o=0, rsp_tag_o=3, one-cycle valid.
//   ALUop=01 (sub), A=B=0x1234 -> rsp_c_o=0, rsp_zero_o=1.
//   rsp_ready_i=0, stream 6 ops (DEPTH=4) -> count_o=4, stage 1 full, req_ready_o=0; release -> all 5 accepted ops emitted in order.
//   Full FIFO, rsp_ready_i=1 with req_valid_i=1 every cycle -> count_o stays 4, one push+pop per cycle, no loss.
//   Wrap: push/pop 10 ops through DEPTH=4 with random rsp_ready_i -> tags 0..9 out in order, count_o matches model.
//   Assert rst_i with 3 entries queued and s1_valid=1 -> next cycle count_o=0, rsp_valid_o=0, req_ready_o=1, no stale output.

Source files
------------

// File: rtl/rd_alu_issue.sv
// Request/response front end for a combinational 64-bit ALU: one operand stage feeding a
// show-ahead response FIFO, so upstream issue and downstream writeback stall independently.
module rd_alu_issue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [63:0]                req_a_i,
  input  logic [63:0]                req_b_i,
  input  logic [3:0]                 req_instr_i,
  input  logic [1:0]                 req_aluop_i,
  input  logic [TAG_W-1:0]           req_tag_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [63:0]                rsp_c_o,
  output logic                       rsp_zero_o,
  output logic [TAG_W-1:0]           rsp_tag_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] DepthCnt = DEPTH[CntW-1:0];

  // Stage 1 operand register
  logic             s1_valid_q, s1_valid_d;
  logic [63:0]      s1_a_q, s1_a_d;
  logic [63:0]      s1_b_q, s1_b_d;
  logic [3:0]       s1_instr_q, s1_instr_d;
  logic [1:0]       s1_aluop_q, s1_aluop_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  // Response FIFO
  logic [63:0]      mem_c_q   [DEPTH];
  logic             mem_zero_q[DEPTH];
  logic [TAG_W-1:0] mem_tag_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  logic        push, pop, accept;
  logic [63:0] alu_c;
  logic        alu_zero;
  logic [5:0]  shamt;

  // ALUop 00 = add, 01 = sub, otherwise decode {funct7[5], funct3} from instruction bits.
  always_comb begin
    alu_c = '0;
    shamt = s1_b_q[5:0];
    case (s1_aluop_q)
      2'b00: alu_c = s1_a_q + s1_b_q;
      2'b01: alu_c = s1_a_q - s1_b_q;
      default: begin
        case (s1_instr_q)
          4'b0000: alu_c = s1_a_q + s1_b_q;
          4'b1000: alu_c = s1_a_q - s1_b_q;
          4'b0111: alu_c = s1_a_q & s1_b_q;
          4'b0110: alu_c = s1_a_q | s1_b_q;
          4'b0100: alu_c = s1_a_q ^ s1_b_q;
          4'b0001: alu_c = s1_a_q << shamt;
          4'b0101: alu_c = s1_a_q >> shamt;
          4'b1101: alu_c = $signed(s1_a_q) >>> shamt;
          4'b0010: alu_c = {63'd0, $signed(s1_a_q) < $signed(s1_b_q)};
          4'b0011: alu_c = {63'd0, s1_a_q < s1_b_q};
          default: alu_c = s1_a_q + s1_b_q;
        endcase
      end
    endcase
    alu_zero = (alu_c == 64'd0);
  end

  assign rsp_valid_o = (count_q != '0);
  assign pop         = rsp_valid_o && rsp_ready_i;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push        = s1_valid_q && ((count_q < DepthCnt) || pop);
  assign req_ready_o = !s1_valid_q || push;
  assign accept      = req_valid_i && req_ready_o;

  assign rsp_c_o    = mem_c_q[rd_ptr_q];
  assign rsp_zero_o = mem_zero_q[rd_ptr_q];
  assign rsp_tag_o  = mem_tag_q[rd_ptr_q];
  assign count_o    = count_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_instr_d = s1_instr_q;
    s1_aluop_d = s1_aluop_q;
    s1_tag_d   = s1_tag_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_a_d     = req_a_i;
      s1_b_d     = req_b_i;
      s1_instr_d = req_instr_i;
      s1_aluop_d = req_aluop_i;
      s1_tag_d   = req_tag_i;
    end else if (push) begin
      s1_valid_d = 1'b0;
    end

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_instr_q <= '0;
      s1_aluop_q <= '0;
      s1_tag_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_c_q[i]    <= '0;
        mem_zero_q[i] <= 1'b0;
        mem_tag_q[i]  <= '0;
      end
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_instr_q <= s1_instr_d;
      s1_aluop_q <= s1_aluop_d;
      s1_tag_q   <= s1_tag_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      if (push) begin
        mem_c_q[wr_ptr_q]    <= alu_c;
        mem_zero_q[wr_ptr_q] <= alu_zero;
        mem_tag_q[wr_ptr_q]  <= s1_tag_q;
      end
    end
  end

endmodule
